// File: rtl/hazard_stall_if.sv
// Decode/execute instruction bus and the stall/bubble controls returned to the pipeline.
interface hazard_stall_if;
  logic [15:0] inst_id;    // instruction in IF/ID
  logic [15:0] inst_ex;    // instruction in ID/EX
  logic        stall_if;   // hold PC and IF/ID
  logic        bubble_ex;  // load nop into ID/EX
  logic        hold_ex;    // hold ID/EX
  logic        bubble_m;   // load nop into EX/M
  logic        md_start;   // start multiplier/divider
  logic        md_done;    // last EX cycle of MUL/DIV
  logic [15:0] stall_cnt;  // saturating stall-cycle counter

  // Pipeline side: presents instructions, consumes controls.
  modport master (
    output inst_id,
    output inst_ex,
    input  stall_if,
    input  bubble_ex,
    input  hold_ex,
    input  bubble_m,
    input  md_start,
    input  md_done,
    input  stall_cnt
  );

  // Interlock side: observes instructions, drives controls.
  modport slave (
    input  inst_id,
    input  inst_ex,
    output stall_if,
    output bubble_ex,
    output hold_ex,
    output bubble_m,
    output md_start,
    output md_done,
    output stall_cnt
  );
endinterface

// File: rtl/hazard_stall.sv
// Pipeline interlock for the Folio CPU: stalls on load-use hazards and while a
// multi-cycle MUL/DIV occupies EX, and counts stall cycles.
module hazard_stall #(
  parameter logic [3:0]  LW_OP   = 4'h8,
  parameter logic [3:0]  MUL_FN  = 4'h4,
  parameter logic [3:0]  DIV_FN  = 4'h5,
  parameter int unsigned MUL_CYC = 3,
  parameter int unsigned DIV_CYC = 8
) (
  input logic           clk,
  input logic           rst_n,
  hazard_stall_if.slave bus
);

  localparam logic [3:0]  MdOp     = 4'hF;
  localparam logic [3:0]  MulCycM1 = 4'(MUL_CYC - 1);
  localparam logic [3:0]  DivCycM1 = 4'(DIV_CYC - 1);
  localparam logic [15:0] CntMax   = 16'hFFFF;

  typedef enum logic [0:0] {StIdle, StMdBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Field decode
  logic [3:0] op_ex, fn_ex, dst_ex;
  logic [3:0] op_id, rs1_id, rs2_id;
  logic       id_nop, id_is_lw, id_reads_op1, id_reads_op2;
  logic       is_mul, is_div, is_md, ex_is_lw, load_use;
  logic [3:0] md_cyc_m1;
  logic       unused_ex;

  assign op_ex  = bus.inst_ex[15:12];
  assign dst_ex = bus.inst_ex[11:8];
  assign fn_ex  = bus.inst_ex[3:0];
  assign op_id  = bus.inst_id[15:12];
  assign rs1_id = bus.inst_id[11:8];
  assign rs2_id = bus.inst_id[7:4];

  // op2 of the EX instruction never matters here.
  assign unused_ex = ^bus.inst_ex[7:4];

  // Read-set of the decode instruction: LW reads only op2, a nop reads nothing.
  assign id_nop       = (bus.inst_id == 16'h0000);
  assign id_is_lw     = (op_id == LW_OP);
  assign id_reads_op1 = !id_nop && !id_is_lw;
  assign id_reads_op2 = !id_nop;

  assign is_mul    = (op_ex == MdOp) && (fn_ex == MUL_FN);
  assign is_div    = (op_ex == MdOp) && (fn_ex == DIV_FN);
  assign is_md     = is_mul || is_div;
  assign md_cyc_m1 = is_div ? DivCycM1 : MulCycM1;

  // $0 is an ordinary register, so no zero-register exemption.
  assign ex_is_lw = (op_ex == LW_OP);
  assign load_use = ex_is_lw && !id_nop &&
                    ((id_reads_op1 && (rs1_id == dst_ex)) ||
                     (id_reads_op2 && (rs2_id == dst_ex)));

  // State, EX-cycle counter and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state: MUL/DIV entry from IDLE, count down remaining EX cycles in MD_BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (is_md) begin
          state_d = StMdBusy;
          cnt_d   = md_cyc_m1;
        end
      end
      StMdBusy: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last EX cycle; the pipeline advances so the same op never re-triggers.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  logic stall_if, bubble_ex, hold_ex, bubble_m, md_start, md_done;

  // Control outputs: combinational, forced low while reset is asserted
  always_comb begin
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    hold_ex   = 1'b0;
    bubble_m  = 1'b0;
    md_start  = 1'b0;
    md_done   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (is_md) begin
            stall_if = 1'b1;
            hold_ex  = 1'b1;
            bubble_m = 1'b1;
            md_start = 1'b1;
          end else if (load_use) begin
            // The load reaches M next cycle, so one bubble clears the hazard.
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        StMdBusy: begin
          // load_use is ignored: EX holds the MUL/DIV, not a load.
          if (cnt_q > 4'd1) begin
            stall_if = 1'b1;
            hold_ex  = 1'b1;
            bubble_m = 1'b1;
          end else begin
            md_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating stall-cycle counter for performance analysis
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_if  = stall_if;
  assign bus.bubble_ex = bubble_ex;
  assign bus.hold_ex   = hold_ex;
  assign bus.bubble_m  = bubble_m;
  assign bus.md_start  = md_start;
  assign bus.md_done   = md_done;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Scoreboard bench for hazard_stall: directed vectors push expected controls,
// a negedge monitor pops and compares.
module tb_hazard_stall;

  logic clk;
  logic rst_n;

  hazard_stall_if bus ();

  hazard_stall #(
    .LW_OP  (4'h8),
    .MUL_FN (4'h4),
    .DIV_FN (4'h5),
    .MUL_CYC(3),
    .DIV_CYC(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {stall_if, bubble_ex, hold_ex, bubble_m, md_start, md_done}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110000;
  localparam logic [5:0] MDS  = 6'b101110;
  localparam logic [5:0] MDB  = 6'b101100;
  localparam logic [5:0] MDD  = 6'b000001;

  typedef struct {
    logic [5:0]  ctrl;
    logic [15:0] cnt;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_n    = 0;
  int   cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one cycle of stimulus and queue its expected response.
  task automatic step(input logic [15:0] id, input logic [15:0] ex, input logic rst,
                      input logic [5:0] ctrl, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    bus.inst_id = id;
    bus.inst_ex = ex;
    rst_n       = rst;
    e.ctrl = ctrl;
    e.cnt  = cnt;
    e.tag  = vec_n;
    exp_q.push_back(e);
    vec_n++;
  endtask

  // Monitor: sample mid-cycle, pop expected entry and compare.
  initial begin
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.md_done) done_q.push_back(cyc);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.stall_if, bus.bubble_ex, bus.hold_ex, bus.bubble_m,
               bus.md_start, bus.md_done};
        n_checks++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl vec%0d: got %b expected %b", e.tag, act, e.ctrl);
        end
        n_checks++;
        if (bus.stall_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL stall_cnt vec%0d: got %0d expected %0d", e.tag, bus.stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.inst_id = 16'h0000;
    bus.inst_ex = 16'h0000;

    // Reset state
    step(16'h0000, 16'h0000, 1'b0, NONE, 16'd0);

    // Nop stream
    for (int i = 0; i < 5; i++) step(16'h0000, 16'h0000, 1'b1, NONE, 16'd0);

    // Load-use: LW $1 in EX, decode reads $1
    step(16'hF310, 16'h8120, 1'b1, LU,   16'd0);
    step(16'h0000, 16'h0000, 1'b1, NONE, 16'd1);

    // Load with and without hazard, LW-reads-op2 rule, $0 not exempt, nop in decode
    step(16'hF450, 16'h8120, 1'b1, NONE, 16'd1);
    step(16'h8210, 16'h8120, 1'b1, LU,   16'd1);
    step(16'h8130, 16'h8120, 1'b1, NONE, 16'd2);
    step(16'hF000, 16'h8020, 1'b1, LU,   16'd2);
    step(16'h0000, 16'h8020, 1'b1, NONE, 16'd3);
    step(16'hF034, 16'h8320, 1'b1, LU,   16'd3);
    step(16'h0000, 16'h0000, 1'b1, NONE, 16'd4);

    // MUL, 3 EX cycles
    step(16'h8120, 16'hF124, 1'b1, MDS,  16'd4);
    step(16'h8120, 16'hF124, 1'b1, MDB,  16'd5);
    step(16'h8120, 16'hF124, 1'b1, MDD,  16'd6);
    step(16'h0000, 16'h0000, 1'b1, NONE, 16'd6);

    // Back-to-back DIV, 8 EX cycles each; a load-use pattern mid-DIV is ignored
    for (int i = 0; i < 8; i++)
      step(16'hF310, (i == 1) ? 16'h8120 : 16'hF125, 1'b1,
           (i == 0) ? MDS : ((i == 7) ? MDD : MDB), 16'(6 + i));
    for (int i = 0; i < 8; i++)
      step(16'h0000, 16'hF125, 1'b1,
           (i == 0) ? MDS : ((i == 7) ? MDD : MDB), 16'(13 + i));
    step(16'h0000, 16'h0000, 1'b1, NONE, 16'd20);

    // Reset at cycle 3 of a DIV: outputs and counter clear without a clock edge
    step(16'h0000, 16'hF125, 1'b1, MDS,  16'd20);
    step(16'h0000, 16'hF125, 1'b1, MDB,  16'd21);
    step(16'h0000, 16'hF125, 1'b1, MDB,  16'd22);
    step(16'h0000, 16'hF125, 1'b0, NONE, 16'd0);
    step(16'h0000, 16'h0000, 1'b0, NONE, 16'd0);
    for (int i = 0; i < 3; i++) step(16'h0000, 16'h0000, 1'b1, NONE, 16'd0);

    // Recovery: a fresh MUL after reset
    step(16'h0000, 16'hF124, 1'b1, MDS,  16'd0);
    step(16'h0000, 16'hF124, 1'b1, MDB,  16'd1);
    step(16'h0000, 16'hF124, 1'b1, MDD,  16'd2);
    step(16'h0000, 16'h0000, 1'b1, NONE, 16'd2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    // md_done: MUL, two DIVs, recovery MUL; aborted DIV gives none
    n_checks++;
    if (done_q.size() != 4) begin
      n_fail++;
      $display("FAIL md_done_count: got %0d expected 4", done_q.size());
    end else begin
      n_checks++;
      if (done_q[2] - done_q[1] != 8) begin
        n_fail++;
        $display("FAIL div_spacing: got %0d expected 8", done_q[2] - done_q[1]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
